// File: rtl/rv32i_writeback_ctl.sv
// Handshaked rv32i writeback stage: computes rd value / next PC, waits on late
// load data with a timeout, and presents the result through one output register.
module rv32i_writeback_ctl #(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [4:0]      rd_idx,
  input  logic [10:0]     opcode,
  input  logic [XLEN-1:0] data_load,
  input  logic            data_load_valid,
  input  logic            flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] rd,
  output logic [4:0]      rd_idx_o,
  output logic            wr_rd,
  output logic [XLEN-1:0] pc_new,
  output logic            exc,
  output logic [1:0]      exc_cause
);

  localparam int OP_RTYPE = 0;
  localparam int OP_ITYPE = 1;
  localparam int OP_LOAD  = 2;
  localparam int OP_STORE = 3;
  localparam int OP_BR    = 4;
  localparam int OP_JAL   = 5;
  localparam int OP_JALR  = 6;
  localparam int OP_LUI   = 7;
  localparam int OP_AUIPC = 8;
  localparam int OP_SYS   = 9;
  localparam int OP_FENCE = 10;

  localparam logic [7:0] TO_CNT = 8'(LOAD_TIMEOUT);

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_MISAL = 2'b01;
  localparam logic [1:0] CAUSE_LDTO  = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] rd;
    logic [4:0]      idx;
    logic            wr;
    logic [XLEN-1:0] pc_new;
    logic            exc;
    logic [1:0]      cause;
  } wb_t;

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  state_t          r_state;
  logic [7:0]      r_cnt;
  logic            r_out_vld;
  wb_t             r_out;
  logic [XLEN-1:0] r_ld_pc4;
  logic [4:0]      r_ld_idx;

  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_pc4;
  logic            w_redir;
  logic            w_accept;
  logic            w_is_load;
  wb_t             w_new;
  wb_t             w_ld_res;
  wb_t             w_to_res;

  assign o_ready   = (r_state == S_IDLE) && (!r_out_vld || i_ready);
  assign w_accept  = i_valid && o_ready && !flush;
  assign w_is_load = opcode[OP_LOAD];

  // Single shared adder: jalr is the only opcode that bases off rs1.
  always_comb begin
    w_sum   = (opcode[OP_JALR] ? rs1 : pc) + imm;
    w_pc4   = pc + XLEN'(4);
    w_redir = (opcode[OP_BR] & alu_out[0]) | opcode[OP_JAL] | opcode[OP_JALR];

    w_new        = '0;
    w_new.idx    = rd_idx;
    w_new.pc_new = w_pc4;
    if (opcode[OP_JALR])
      w_new.pc_new = {w_sum[XLEN-1:1], 1'b0};
    else if (w_redir)
      w_new.pc_new = w_sum;

    if (opcode[OP_RTYPE] || opcode[OP_ITYPE])
      w_new.rd = alu_out;
    else if (opcode[OP_LOAD])
      w_new.rd = data_load;
    else if (opcode[OP_JAL] || opcode[OP_JALR])
      w_new.rd = w_pc4;
    else if (opcode[OP_LUI])
      w_new.rd = imm;
    else if (opcode[OP_AUIPC])
      w_new.rd = w_sum;

    // The target is still reported even when it faults.
    if (w_redir && (w_new.pc_new[1:0] != 2'b00)) begin
      w_new.exc   = 1'b1;
      w_new.cause = CAUSE_MISAL;
    end else begin
      w_new.cause = CAUSE_NONE;
    end

    w_new.wr = !(opcode[OP_BR] | opcode[OP_STORE] | opcode[OP_SYS] | opcode[OP_FENCE])
               && (rd_idx != 5'd0) && !w_new.exc;
  end

  always_comb begin
    w_ld_res        = '0;
    w_ld_res.rd     = data_load;
    w_ld_res.idx    = r_ld_idx;
    w_ld_res.wr     = (r_ld_idx != 5'd0);
    w_ld_res.pc_new = r_ld_pc4;
    w_ld_res.cause  = CAUSE_NONE;

    w_to_res        = '0;
    w_to_res.idx    = r_ld_idx;
    w_to_res.pc_new = r_ld_pc4;
    w_to_res.exc    = 1'b1;
    w_to_res.cause  = CAUSE_LDTO;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_out_vld <= 1'b0;
      r_out     <= '0;
      r_ld_pc4  <= '0;
      r_ld_idx  <= 5'd0;
    end else if (flush) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_out_vld <= 1'b0;
    end else begin
      if (r_out_vld && i_ready)
        r_out_vld <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_load && !data_load_valid) begin
              r_state  <= S_WAIT;
              r_cnt    <= 8'd0;
              r_ld_pc4 <= w_pc4;
              r_ld_idx <= rd_idx;
            end else begin
              r_out_vld <= 1'b1;
              r_out     <= w_new;
            end
          end
        end
        S_WAIT: begin
          // Data arriving on the timeout cycle still counts as a good load.
          if (data_load_valid) begin
            r_out_vld <= 1'b1;
            r_out     <= w_ld_res;
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
          end else if (r_cnt == TO_CNT) begin
            r_out_vld <= 1'b1;
            r_out     <= w_to_res;
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_valid   = r_out_vld;
  assign rd        = r_out.rd;
  assign rd_idx_o  = r_out.idx;
  assign wr_rd     = r_out.wr;
  assign pc_new    = r_out.pc_new;
  assign exc       = r_out.exc;
  assign exc_cause = r_out.cause;

endmodule

// File: tb/tb_rv32i_writeback_ctl.sv
// Scoreboard bench for rv32i_writeback_ctl: expectations queued on accept,
// compared on every output handshake, plus direct checks on stalls/flush/timeout.
module tb_rv32i_writeback_ctl;

  localparam int XLEN = 32;
  localparam int LT   = 15;

  localparam logic [10:0] OP_R    = 11'd1 << 0;
  localparam logic [10:0] OP_I    = 11'd1 << 1;
  localparam logic [10:0] OP_LD   = 11'd1 << 2;
  localparam logic [10:0] OP_ST   = 11'd1 << 3;
  localparam logic [10:0] OP_BR   = 11'd1 << 4;
  localparam logic [10:0] OP_JAL  = 11'd1 << 5;
  localparam logic [10:0] OP_JALR = 11'd1 << 6;
  localparam logic [10:0] OP_LUI  = 11'd1 << 7;
  localparam logic [10:0] OP_AUI  = 11'd1 << 8;

  logic clk = 1'b0;
  logic rst;
  logic i_valid, o_ready, data_load_valid, flush, o_valid, i_ready;
  logic [XLEN-1:0] alu_out, pc, imm, rs1, data_load, rd, pc_new;
  logic [4:0] rd_idx, rd_idx_o;
  logic [10:0] opcode;
  logic wr_rd, exc;
  logic [1:0] exc_cause;

  typedef struct {
    logic [31:0] rd;
    logic        rd_dc;
    logic [4:0]  idx;
    logic        wr;
    logic [31:0] pcn;
    logic        exc;
    logic [1:0]  cause;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32i_writeback_ctl #(.XLEN(XLEN), .LOAD_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .alu_out(alu_out), .pc(pc), .imm(imm), .rs1(rs1), .rd_idx(rd_idx),
    .opcode(opcode), .data_load(data_load), .data_load_valid(data_load_valid),
    .flush(flush), .o_valid(o_valid), .i_ready(i_ready), .rd(rd),
    .rd_idx_o(rd_idx_o), .wr_rd(wr_rd), .pc_new(pc_new), .exc(exc),
    .exc_cause(exc_cause)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [10:0] op, input logic [31:0] a,
                                 input logic [31:0] p, input logic [31:0] im,
                                 input logic [31:0] r1, input logic [4:0] ri,
                                 input logic [31:0] dl);
    exp_t e;
    logic [31:0] base, tgt, p4;
    logic jump;
    base = op[6] ? r1 : p;
    tgt  = base + im;
    p4   = p + 32'd4;
    jump = (op[4] && a[0]) || op[5] || op[6];
    e.pcn = p4;
    if (op[6]) e.pcn = tgt & ~32'd1;
    else if (jump) e.pcn = tgt;
    case (op)
      OP_R, OP_I:     e.rd = a;
      OP_LD:          e.rd = dl;
      OP_JAL, OP_JALR: e.rd = p4;
      OP_LUI:         e.rd = im;
      OP_AUI:         e.rd = tgt;
      default:        e.rd = 32'd0;
    endcase
    e.rd_dc = 1'b0;
    e.idx   = ri;
    e.exc   = jump && (e.pcn[1:0] != 2'b00);
    e.cause = e.exc ? 2'b01 : 2'b00;
    e.wr    = !(op[3] || op[4] || op[9] || op[10]) && (ri != 5'd0) && !e.exc;
    return e;
  endfunction

  // Output-side scoreboard.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", o_valid, 1'b0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (!e.rd_dc) chk("sb_rd", rd, e.rd);
        chk("sb_idx", rd_idx_o, e.idx);
        chk("sb_wr", wr_rd, e.wr);
        chk("sb_pcn", pc_new, e.pcn);
        chk("sb_exc", exc, e.exc);
        chk("sb_cause", exc_cause, e.cause);
      end
    end
  end

  // kind: 0 = no expectation, 1 = model, 2 = load timeout
  task automatic send(input logic [10:0] op, input logic [31:0] a, input logic [31:0] p,
                      input logic [31:0] im, input logic [31:0] r1, input logic [4:0] ri,
                      input logic [31:0] dl, input logic dlv, input int kind);
    int n;
    exp_t e;
    opcode = op; alu_out = a; pc = p; imm = im; rs1 = r1; rd_idx = ri;
    data_load = dl; data_load_valid = dlv; i_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) chk("accept_timeout", o_ready, 1'b1);
    if (kind == 1) q.push_back(model(op, a, p, im, r1, ri, dl));
    if (kind == 2) begin
      e.rd = 32'd0; e.rd_dc = 1'b1; e.idx = ri; e.wr = 1'b0;
      e.pcn = p + 32'd4; e.exc = 1'b1; e.cause = 2'b10;
      q.push_back(e);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    data_load_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; i_valid = 1'b0; flush = 1'b0; i_ready = 1'b1;
    alu_out = '0; pc = '0; imm = '0; rs1 = '0; rd_idx = '0; opcode = '0;
    data_load = '0; data_load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ovalid", o_valid, 1'b0);
    chk("rst_oready", o_ready, 1'b1);
    chk("rst_rd", rd, 0);
    chk("rst_idx", rd_idx_o, 0);
    chk("rst_wr", wr_rd, 1'b0);
    chk("rst_pcn", pc_new, 0);
    chk("rst_exc", exc, 1'b0);
    chk("rst_cause", exc_cause, 0);
    @(posedge clk); #1;

    // Back-to-back traffic.
    send(OP_I,    32'd5, 32'h10,  32'd0,  32'd0,      5'd3, 32'd0, 1'b0, 1);
    send(OP_BR,   32'd1, 32'h100, 32'h20, 32'd0,      5'd5, 32'd0, 1'b0, 1);
    send(OP_BR,   32'd0, 32'h200, 32'h20, 32'd0,      5'd5, 32'd0, 1'b0, 1);
    send(OP_JAL,  32'd0, 32'h300, 32'h10, 32'd0,      5'd1, 32'd0, 1'b0, 1);
    send(OP_JALR, 32'd0, 32'h40,  32'h4,  32'h1001,   5'd1, 32'd0, 1'b0, 1);
    send(OP_JALR, 32'd0, 32'h40,  32'h4,  32'h1002,   5'd1, 32'd0, 1'b0, 1);
    send(OP_AUI,  32'd0, 32'h1000, 32'h5000, 32'd0,   5'd6, 32'd0, 1'b0, 1);
    send(OP_LUI,  32'd0, 32'h20,  32'hABCDE000, 32'd0, 5'd7, 32'd0, 1'b0, 1);
    send(OP_ST,   32'h99, 32'h24, 32'd8,  32'd0,      5'd8, 32'd0, 1'b0, 1);
    send(OP_R,    32'h1234, 32'hFFFFFFFC, 32'd0, 32'd0, 5'd2, 32'd0, 1'b0, 1);
    send(OP_LD,   32'd0, 32'h80,  32'd0,  32'd0,      5'd11, 32'hCAFEF00D, 1'b1, 1);
    repeat (3) @(posedge clk); #1;

    // Load with data three cycles late.
    send(OP_LD, 32'd0, 32'h400, 32'd0, 32'd0, 5'd12, 32'hDEADBEEF, 1'b0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ld_wait_ready", o_ready, 1'b0);
      @(posedge clk); #1;
    end
    data_load = 32'hDEADBEEF; data_load_valid = 1'b1;
    @(posedge clk); #1;
    data_load_valid = 1'b0;
    chk("ld_late_ovalid", o_valid, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Load that never returns data.
    send(OP_LD, 32'd0, 32'h500, 32'd0, 32'd0, 5'd9, 32'd0, 1'b0, 2);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!o_valid && n < 100);
    chk("timeout_latency", n, LT + 1);
    repeat (2) @(posedge clk); #1;

    // Data on the very cycle the timeout would fire: data wins.
    send(OP_LD, 32'd0, 32'h600, 32'd0, 32'd0, 5'd10, 32'h12345678, 1'b0, 1);
    repeat (LT) @(posedge clk);
    #1;
    data_load = 32'h12345678; data_load_valid = 1'b1;
    @(posedge clk); #1;
    data_load_valid = 1'b0;
    chk("ld_edge_ovalid", o_valid, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Flush while waiting for load data, then stray load data in IDLE.
    send(OP_LD, 32'd0, 32'h700, 32'd0, 32'd0, 5'd13, 32'd0, 1'b0, 0);
    chk("wait_ready", o_ready, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_wait_ready", o_ready, 1'b1);
    chk("flush_wait_ovalid", o_valid, 1'b0);
    data_load = 32'h55; data_load_valid = 1'b1;
    @(posedge clk); #1;
    data_load_valid = 1'b0;
    chk("stray_data_ovalid", o_valid, 1'b0);

    // Downstream stall, then flush with a bundle presented in the same cycle.
    i_ready = 1'b0;
    send(OP_I, 32'h77, 32'h800, 32'd0, 32'd0, 5'd4, 32'd0, 1'b0, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_ovalid", o_valid, 1'b1);
      chk("stall_ready", o_ready, 1'b0);
      chk("stall_rd", rd, 32'h77);
      chk("stall_pcn", pc_new, 32'h804);
      chk("stall_idx", rd_idx_o, 5'd4);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    opcode = OP_LUI; imm = 32'h1000; rd_idx = 5'd3; i_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; i_valid = 1'b0;
    chk("flush_ovalid", o_valid, 1'b0);
    chk("flush_ready", o_ready, 1'b1);
    void'(q.pop_back());
    i_ready = 1'b1;
    @(posedge clk); #1;
    chk("flush_drop_ovalid", o_valid, 1'b0);

    send(OP_LUI, 32'd0, 32'h900, 32'h7000, 32'd0, 5'd0, 32'd0, 1'b0, 1);
    repeat (3) @(posedge clk); #1;
    chk("sb_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
